// File: rtl/ra_ctrl_pkg.sv
// Shared definitions for the rolling-average controller.
//   NUM_ELEM_DEF : default window depth
//   ADDR_BITS    : window address width for the default depth
//   ra_state_e   : controller FSM states
package ra_ctrl_pkg;

   localparam int unsigned NUM_ELEM_DEF = 8;
   localparam int unsigned ADDR_BITS    = $clog2(NUM_ELEM_DEF);

   typedef enum logic [2:0] {
      StFlush,
      StIdle,
      StRead,
      StCalc,
      StWait
   } ra_state_e;

endpackage

// File: rtl/ra_window_buf.sv
// Circular window storage for the rolling-average controller.
// One synchronous read port (data one cycle after i_rd_en) and one write port.
// The array has no reset; the controller clears it with explicit zero writes.
//   clk        in  clock
//   i_rd_en    in  read request
//   i_rd_addr  in  read address
//   o_rd_data  out registered read data
//   i_wr_en    in  write request
//   i_wr_addr  in  write address
//   i_wr_data  in  write data
module ra_window_buf
   import ra_ctrl_pkg::*;
#(
   parameter int unsigned BITS_PER_ELEM = 5,
   parameter int unsigned NUM_ELEM      = NUM_ELEM_DEF,
   parameter int unsigned ADDR_W        = ADDR_BITS
) (
   input  logic                     clk,
   input  logic                     i_rd_en,
   input  logic [ADDR_W-1:0]        i_rd_addr,
   output logic [BITS_PER_ELEM-1:0] o_rd_data,
   input  logic                     i_wr_en,
   input  logic [ADDR_W-1:0]        i_wr_addr,
   input  logic [BITS_PER_ELEM-1:0] i_wr_data
);

   logic [BITS_PER_ELEM-1:0] r_mem [NUM_ELEM];
   logic [BITS_PER_ELEM-1:0] r_rd_data;

   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
      if (i_rd_en) begin
         r_rd_data <= r_mem[i_rd_addr];
      end
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/rolling_average_ctrl.sv
// Sequencer for the rolling-sum datapath. Accepts one sample per 4 cycles,
// keeps the last NUM_ELEM samples in a circular window, hands new/evicted values
// to the datapath with a start strobe and registers the returned average.
// Window and datapath sum are cleared together on reset and on flush.
// Optional macro RA_CTRL_WARMUP_GATE_EN: suppress o_avg_valid until the window is full.
//   clk, rst                 clock, synchronous active-high reset
//   i_sample/i_sample_valid  sample offer; o_sample_ready accepts
//   i_flush                  level request to clear window and sum
//   o_new/o_old/o_start_calc datapath operands and update strobe
//   o_dp_rst                 datapath clear, high during FLUSH
//   i_ra                     datapath average, valid the cycle after o_start_calc
//   o_avg/o_avg_valid        registered average and qualifier pulse
//   o_window_full            NUM_ELEM samples held since last clear
module rolling_average_ctrl
   import ra_ctrl_pkg::*;
#(
   parameter int unsigned BITS_PER_ELEM = 5,
   parameter int unsigned NUM_ELEM      = NUM_ELEM_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [BITS_PER_ELEM-1:0] i_sample,
   input  logic                     i_sample_valid,
   output logic                     o_sample_ready,
   input  logic                     i_flush,
   output logic [BITS_PER_ELEM-1:0] o_new,
   output logic [BITS_PER_ELEM-1:0] o_old,
   output logic                     o_start_calc,
   output logic                     o_dp_rst,
   input  logic [BITS_PER_ELEM-1:0] i_ra,
   output logic [BITS_PER_ELEM-1:0] o_avg,
   output logic                     o_avg_valid,
   output logic                     o_window_full
);

   localparam int unsigned       ADDR_W    = $clog2(NUM_ELEM);
   localparam int unsigned       FILL_W    = ADDR_W + 1;
   localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(NUM_ELEM);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ELEM - 1);

   ra_state_e                r_state, w_state_next;
   logic [ADDR_W-1:0]        r_ptr, r_flush_cnt;
   logic [FILL_W-1:0]        r_fill_cnt, w_fill_next;
   logic [BITS_PER_ELEM-1:0] r_new_smp, r_new, r_old, r_avg;
   logic                     r_avg_valid, r_window_full, r_flush_pend;
   logic                     w_flush_req, w_flush_done, w_accept;
   logic                     w_ready, w_start, w_dp_rst;
   logic                     w_wr_en;
   logic [ADDR_W-1:0]        w_wr_addr;
   logic [BITS_PER_ELEM-1:0] w_wr_data, w_rd_data;

   // A flush seen outside IDLE is parked in r_flush_pend until IDLE.
   assign w_flush_req  = i_flush | r_flush_pend;
   assign w_accept     = w_ready & i_sample_valid;
   assign w_flush_done = (r_flush_cnt == LAST_ADDR);
   assign w_fill_next  = (r_fill_cnt == FILL_MAX) ? r_fill_cnt : r_fill_cnt + FILL_W'(1);

   ra_window_buf #(
      .BITS_PER_ELEM (BITS_PER_ELEM),
      .NUM_ELEM      (NUM_ELEM),
      .ADDR_W        (ADDR_W)
   ) u_buf (
      .clk       (clk),
      .i_rd_en   (w_accept),
      .i_rd_addr (r_ptr),
      .o_rd_data (w_rd_data),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (w_wr_addr),
      .i_wr_data (w_wr_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StFlush;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StFlush: if (w_flush_done) w_state_next = StIdle;
         StIdle: begin
            if (w_flush_req)         w_state_next = StFlush;
            else if (i_sample_valid) w_state_next = StRead;
         end
         StRead:  w_state_next = StCalc;
         StCalc:  w_state_next = StWait;
         StWait:  w_state_next = StIdle;
         default: w_state_next = StFlush;
      endcase
   end

   // Reads only happen on IDLE accept, writes only in FLUSH/CALC: ports never collide.
   always_comb begin
      w_ready   = 1'b0;
      w_start   = 1'b0;
      w_dp_rst  = 1'b0;
      w_wr_en   = 1'b0;
      w_wr_addr = r_ptr;
      w_wr_data = r_new;
      unique case (r_state)
         StFlush: begin
            w_dp_rst  = 1'b1;
            w_wr_en   = 1'b1;
            w_wr_addr = r_flush_cnt;
            w_wr_data = '0;
         end
         StIdle:  w_ready = ~w_flush_req;
         StCalc: begin
            w_start = 1'b1;
            w_wr_en = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr         <= '0;
         r_flush_cnt   <= '0;
         r_fill_cnt    <= '0;
         r_new_smp     <= '0;
         r_new         <= '0;
         r_old         <= '0;
         r_avg         <= '0;
         r_avg_valid   <= 1'b0;
         r_window_full <= 1'b0;
         r_flush_pend  <= 1'b0;
      end else begin
         r_avg_valid <= 1'b0;
         unique case (r_state)
            StFlush: begin
               // Power-of-two depth: the counter wraps back to 0 on the last entry.
               r_flush_cnt <= r_flush_cnt + ADDR_W'(1);
               if (w_flush_done) begin
                  r_ptr         <= '0;
                  r_fill_cnt    <= '0;
                  r_window_full <= 1'b0;
               end
            end
            StIdle: begin
               if (w_flush_req) r_flush_pend <= 1'b0;
               else if (w_accept) r_new_smp <= i_sample;
            end
            StRead: begin
               r_new <= r_new_smp;
               r_old <= w_rd_data;
            end
            StCalc: begin
               r_ptr         <= r_ptr + ADDR_W'(1);
               r_fill_cnt    <= w_fill_next;
               r_window_full <= (w_fill_next == FILL_MAX);
            end
            StWait: begin
               r_avg <= i_ra;
`ifdef RA_CTRL_WARMUP_GATE_EN
               r_avg_valid <= r_window_full;
`else
               r_avg_valid <= 1'b1;
`endif
            end
            default: ;
         endcase
         if (i_flush && (r_state inside {StRead, StCalc, StWait})) begin
            r_flush_pend <= 1'b1;
         end
      end
   end

   assign o_sample_ready = w_ready;
   assign o_start_calc   = w_start;
   assign o_dp_rst       = w_dp_rst;
   assign o_new          = r_new;
   assign o_old          = r_old;
   assign o_avg          = r_avg;
   assign o_avg_valid    = r_avg_valid;
   assign o_window_full  = r_window_full;

endmodule

// File: doc/rolling_average_ctrl.md
# rolling_average_ctrl

Sequencer for the rolling-sum datapath. It accepts samples over a valid/ready handshake and keeps the last NUM_ELEM samples in a circular window buffer. For each sample it presents the new and evicted-oldest values to the datapath with a one-cycle start strobe, then registers the datapath's average as a qualified output. It also owns window clearing on reset and on flush, keeping the buffer and the datapath sum consistent.

## Interface
- BITS_PER_ELEM, 5, sample and average width
- NUM_ELEM, 8, window depth; power of two, ≥2
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_sample  in  BITS_PER_ELEM  incoming sample
- i_sample_valid  in  1  sample offered
- o_sample_ready  out  1  controller can accept; high only in IDLE with i_flush low
- i_flush  in  1  level request to clear window and sum
- o_new  out  BITS_PER_ELEM  datapath new value
- o_old  out  BITS_PER_ELEM  datapath evicted value
- o_start_calc  out  1  datapath update strobe, one cycle per sample
- o_dp_rst  out  1  datapath clear, high throughout FLUSH
- i_ra  in  BITS_PER_ELEM  datapath average; valid the cycle after o_start_calc
- o_avg  out  BITS_PER_ELEM  registered average
- o_avg_valid  out  1  one-cycle pulse qualifying o_avg
- o_window_full  out  1  NUM_ELEM samples held since last clear

## Operation
- States: FLUSH, IDLE, READ, CALC, WAIT.
- Reset enters FLUSH. Reset values: ptr=0, flush_cnt=0, fill_cnt=0, o_avg=0, o_avg_valid=0, o_start_calc=0, o_dp_rst=1 (FLUSH), o_sample_ready=0.
- FLUSH: writes 0 to buffer[flush_cnt], one entry per cycle. o_dp_rst is high. After NUM_ELEM cycles it goes to IDLE with ptr=0 and fill_cnt=0.
- IDLE, i_flush=1: goes to FLUSH. Flush has priority over a sample; ready is low that cycle.
- IDLE, valid&ready: latches i_sample into new_reg, issues a buffer read at ptr, goes to READ.
- READ: read data returns (synchronous read, 1 cycle). Captures it into old_reg. Goes to CALC.
- CALC: o_start_calc=1, o_new=new_reg, o_old=old_reg. Writes new_reg to buffer[ptr]. ptr increments modulo NUM_ELEM, wrapping NUM_ELEM-1→0. fill_cnt saturates at NUM_ELEM. Goes to WAIT.
- WAIT: o_avg<=i_ra, o_avg_valid<=1 (subject to the config gate). Goes to IDLE.
- o_new and o_old hold their last values outside CALC and are zero after reset.
- Warm-up: zeroed slots make o_old=0 until the window is full, matching the cleared datapath sum.
- i_flush outside IDLE is not dropped; it is honoured on the next IDLE cycle.
- rst in any state, including mid-FLUSH, restarts a full FLUSH from flush_cnt=0 and cancels any pending o_avg_valid.
- o_window_full = (fill_cnt == NUM_ELEM), registered.

## Timing
- Sample accepted at edge T:
  - READ during T+1.
  - o_start_calc high during T+2.
  - WAIT during T+3.
  - o_avg_valid high during T+4; IDLE and ready high during T+4.
- Throughput: one sample per 4 cycles.
- Flush/reset: ready low for exactly NUM_ELEM cycles after rst deasserts or after FLUSH entry.
- The buffer read port and write port are never active in the same cycle.

## Configuration
- RA_CTRL_WARMUP_GATE_EN defined: o_avg_valid is suppressed until o_window_full is 1. The first qualified pulse follows the NUM_ELEM-th sample. o_avg still updates.
- Undefined: every sample produces an o_avg_valid pulse, including partial-window (warm-up) averages.

## Structure
- Package ra_ctrl_pkg:
  - state enum typedef
  - NUM_ELEM default
  - ADDR_BITS = $clog2(NUM_ELEM)
- Sub-module ra_window_buf:
  - NUM_ELEM × BITS_PER_ELEM array
  - one synchronous read port and one write port
  - no reset on the array; clearing is done by FLUSH writes

## Test plan
- Reset release → o_dp_rst high and ready low for 8 cycles, then ready=1; all outputs at reset values.
- Eight samples of 16 (datapath model: 8-bit sum, top 5 bits) → o_old=0 each; 8th o_avg=16; o_window_full rises after 8th CALC.
- Eight samples of 31, then one 0 → 9th o_old=31, o_avg=27 (sum 217); ptr wraps to 1.
- i_sample_valid held high continuously → one accept per 4 cycles, o_start_calc never back-to-back, no sample lost or duplicated.
- i_flush pulsed during CALC → sample completes with o_avg_valid, then 8-cycle FLUSH; next sample 5 yields o_old=0, fill_cnt=1.
- RA_CTRL_WARMUP_GATE_EN defined, samples 1..8 → no o_avg_valid for the first seven; one pulse after the eighth.
